data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port.
- Accepts byte-strobed read and write requests via a valid/ready handshake and inserts a configurable number of wait states.
- Returns one response per request: read data, or write completion, plus an error flag.
- Sits between the CPU data bus and a word-organised RAM; lets the bench model non-zero-latency data memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array.
- BASE_ADDR, 32'h80000000: byte address that maps to word 0.
- WAIT_STATES, 2: cycles between accept and response. Range 0..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- mem_rw  in  1  1 = write, 0 = read.
- mem_wstrobe  in  4  byte-lane mask, low-lane justified: 0001 = byte, 0011 = half, 1111 = word.
- addr  in  32  byte address.
- wdata  in  32  write data, low-lane justified.
- rsp_valid  out  1  response valid; one-cycle pulse.
- rdata  out  32  read data, low-lane justified; unmasked lanes are 0.
- rsp_err  out  1  request was misaligned or out of range; qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=0 while reset is asserted, then 1 on the first clk after deassertion. rsp_valid=0, rdata=0, rsp_err=0. The FSM goes to IDLE and the wait counter clears. Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready=1 in IDLE and RESP, 0 in WAIT.
- Accept occurs when req_valid & req_ready at a clk edge. On accept, latch mem_rw, mem_wstrobe, addr and wdata.
- Transition on accept: if WAIT_STATES==0, go to RESP; otherwise go to WAIT and load the counter with WAIT_STATES-1.
- WAIT: decrement the counter each cycle; when it is 0, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; there is no backpressure. If a new request is accepted in the same cycle, go to WAIT or RESP as from IDLE; otherwise go to IDLE.
- Latency: rsp_valid is asserted WAIT_STATES+1 cycles after the accept edge. Back-to-back throughput is one request per WAIT_STATES+1 cycles.
- Address decode:
  - off = addr - BASE_ADDR, 32-bit unsigned with wrap, so addresses below the base wrap high.
  - word index = off[31:2]; lane = off[1:0].
  - Out of range when off >= DEPTH_WORDS*4.
- Lane alignment: effective strobe = mem_wstrobe << lane. Misaligned when any shifted bit falls beyond bit 3 (word with lane!=0, half with lane==3) or when the strobe is 0000.
- Errors (out of range or misaligned): no array write, rdata=0, rsp_err=1.
- Write: the array word is updated only on enabled lanes, using wdata << 8*lane. The write commits on the edge entering RESP. rdata=0 for writes.
- Read: word >> 8*lane, masked by mem_wstrobe. The array is sampled on the edge entering RESP, so a read accepted after a write to the same address returns the new data.
- Reset mid-operation: the pending request is discarded with no write and no response. A write commits only if its RESP-entry edge precedes reset.
- rdata and rsp_err hold their values outside RESP; they are meaningful only with rsp_valid.

Optional Feature:
- Macro: DMEM_RESP_STATS_EN.
- When defined: add output ports rd_cnt[15:0], wr_cnt[15:0] and err_cnt[15:0].
  - Each counter increments on rsp_valid for successful reads, successful writes and errors respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write then read word, WAIT_STATES=2: SW addr=80000010, wdata=DEADBEEF, strobe=1111; then read with strobe=1111. Each response comes 3 cycles after accept; rdata=DEADBEEF, rsp_err=0.
- Byte and half write at offsets: preload 80000020=00000000. Write byte AB at 80000023, then half 1234 at 80000020, then read the word → 0xAB001234. A byte read at 80000023 returns 000000AB.
- Misaligned and out of range: word at 80000002, half at 80000003, and addr 80001000 with DEPTH_WORDS=1024 → rsp_err=1, rdata=0, array unchanged. addr 7FFFFFFC → rsp_err=1.
- Back-to-back, WAIT_STATES=0: req_valid held high for 4 reads. req_ready stays 1 throughout, and rsp_valid is high on 4 consecutive cycles starting 1 cycle after the first accept.
- Reset mid-op: accept a write of 11111111 to 80000030 (old value 22222222) with WAIT_STATES=3. Pulse reset during WAIT. No rsp_valid follows, req_ready=0 during reset, and a subsequent read returns 22222222.
- With DMEM_RESP_STATS_EN defined: 3 good reads, 2 good writes and 1 error → rd_cnt=3, wr_cnt=2, err_cnt=1. Reset clears all three to 0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-port bus between the CPU data side (master) and data_mem_responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rw;
    logic [3:0]  mem_wstrobe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;

    modport master (
        output req_valid, mem_rw, mem_wstrobe, addr, wdata,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, mem_rw, mem_wstrobe, addr, wdata,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request port with a fixed wait-state latency.
// Optional response statistics counters are enabled by defining DMEM_RESP_STATS_EN.
// state | meaning
// IDLE  | nothing outstanding, ready for a request
// WAIT  | request latched, counting down wait states
// RESP  | response presented this cycle, ready for the next request
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    data_mem_responder_if.slave bus
`ifdef DMEM_RESP_STATS_EN
    ,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam int unsigned IDXW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        rw_q;
    logic [3:0]  strb_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic            accept, go_resp, mem_we, oor;
    logic            src_rw;
    logic [3:0]      src_strb;
    logic [31:0]     src_addr, src_wdata, off;
    logic [1:0]      lane;
    logic [7:0]      lane_strb;
    logic [IDXW-1:0] widx;
    logic [31:0]     rword, wword, rmask, wmask;

    // With zero wait states the response is built from the request being accepted this edge.
    always_comb begin
        accept    = bus.req_valid & ready_q;
        src_rw    = accept ? bus.mem_rw      : rw_q;
        src_strb  = accept ? bus.mem_wstrobe : strb_q;
        src_addr  = accept ? bus.addr        : addr_q;
        src_wdata = accept ? bus.wdata       : wdata_q;
        off       = src_addr - BASE_ADDR;
        lane      = off[1:0];
        lane_strb = {4'b0000, src_strb} << lane;
        oor       = (off >= DEPTH_BYTES);
        err_d     = oor | (|lane_strb[7:4]) | (src_strb == 4'b0000);
        widx      = oor ? '0 : off[IDXW+1:2];
        rword     = mem_q[widx];
        rmask     = '0;
        wmask     = '0;
        for (int i = 0; i < 4; i++) begin
            rmask[8*i +: 8] = {8{src_strb[i]}};
            wmask[8*i +: 8] = {8{lane_strb[i]}};
        end
        wword   = (rword & ~wmask) | ((src_wdata << {lane, 3'b000}) & wmask);
        rdata_d = (err_d | src_rw) ? '0 : ((rword >> {lane, 3'b000}) & rmask);

        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != WAIT);
        mem_we  = go_resp & src_rw & ~err_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rw_q        <= 1'b0;
            strb_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= go_resp;
            if (accept) begin
                rw_q    <= bus.mem_rw;
                strb_q  <= bus.mem_wstrobe;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (go_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Array contents survive reset; no write can be pending because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[widx] <= wword;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.rsp_err   = err_q;

`ifdef DMEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (go_resp) begin
            if (err_d) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (src_rw) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (2, 0 and 3 wait states) against a byte-level memory model.
module tb_data_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

`ifdef DMEM_RESP_STATS_EN
    logic [15:0] rd_c0, wr_c0, er_c0, rd_c1, wr_c1, er_c1, rd_c2, wr_c2, er_c2;
`endif

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(2)) u0 (
        .clk(clk), .reset(reset), .bus(bus0)
`ifdef DMEM_RESP_STATS_EN
        , .rd_cnt(rd_c0), .wr_cnt(wr_c0), .err_cnt(er_c0)
`endif
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(0)) u1 (
        .clk(clk), .reset(reset), .bus(bus1)
`ifdef DMEM_RESP_STATS_EN
        , .rd_cnt(rd_c1), .wr_cnt(wr_c1), .err_cnt(er_c1)
`endif
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_STATES(3)) u2 (
        .clk(clk), .reset(reset), .bus(bus2)
`ifdef DMEM_RESP_STATS_EN
        , .rd_cnt(rd_c2), .wr_cnt(wr_c2), .err_cnt(er_c2)
`endif
    );

    // Reference memory: one byte array per responder, indexed by byte offset from BASE.
    logic [7:0] mbytes [0:2][0:4095];

    function automatic int ws_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int width_of(input logic [3:0] st);
        case (st)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model(input int d, input logic rw, input logic [3:0] st, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_er);
        logic [31:0] off;
        int w, lane;
        off    = a - BASE;
        w      = width_of(st);
        lane   = int'(off % 4);
        exp_er = (off >= 32'd4096) || (w == 0) || (lane + w > 4);
        exp_rd = '0;
        if (!exp_er) begin
            for (int i = 0; i < w; i++) begin
                if (rw) mbytes[d][int'(off) + i] = wd[8*i +: 8];
                else    exp_rd[8*i +: 8] = mbytes[d][int'(off) + i];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic rw, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        case (d)
            0: begin bus0.req_valid = v; bus0.mem_rw = rw; bus0.mem_wstrobe = st; bus0.addr = a; bus0.wdata = wd; end
            1: begin bus1.req_valid = v; bus1.mem_rw = rw; bus1.mem_wstrobe = st; bus1.addr = a; bus1.wdata = wd; end
            default: begin bus2.req_valid = v; bus2.mem_rw = rw; bus2.mem_wstrobe = st; bus2.addr = a; bus2.wdata = wd; end
        endcase
    endtask

    function automatic logic ready_of(input int d);
        case (d)
            0:       return bus0.req_ready;
            1:       return bus1.req_ready;
            default: return bus2.req_ready;
        endcase
    endfunction

    function automatic logic rsp_of(input int d);
        case (d)
            0:       return bus0.rsp_valid;
            1:       return bus1.rsp_valid;
            default: return bus2.rsp_valid;
        endcase
    endfunction

    function automatic logic [31:0] rdata_of(input int d);
        case (d)
            0:       return bus0.rdata;
            1:       return bus1.rdata;
            default: return bus2.rdata;
        endcase
    endfunction

    function automatic logic err_of(input int d);
        case (d)
            0:       return bus0.rsp_err;
            1:       return bus1.rsp_err;
            default: return bus2.rsp_err;
        endcase
    endfunction

    // One request through the DUT; latency counts edges from accept to the edge that sees rsp_valid.
    task automatic do_xact(input string tag, input int d, input logic rw, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic exp_er, er;
        int guard, lat;
        model(d, rw, st, a, wd, exp_rd, exp_er);
        @(negedge clk);
        drive(d, 1'b1, rw, st, a, wd);
        guard = 0;
        while (!ready_of(d) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(ready_of(d)), 32'd1);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        lat = 1;
        while (!rsp_of(d) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp"}, 32'(rsp_of(d)), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(ws_of(d) + 1));
        rd = rdata_of(d);
        er = err_of(d);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] b2b_exp [4];
        logic [31:0] a;
        logic [3:0]  st;
        logic        dummy_er;
        logic [3:0]  st_tab [4];
        int seen, guard;

        st_tab[0] = 4'b0000; st_tab[1] = 4'b0001; st_tab[2] = 4'b0011; st_tab[3] = 4'b1111;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus0.req_ready), 32'd0);
        check("rst_rsp", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rdata", bus0.rdata, 32'h0);
        check("rst_err", 32'(bus0.rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(bus0.req_ready), 32'd1);
`ifdef DMEM_RESP_STATS_EN
        check("rst_rd_cnt", 32'(rd_c0), 32'd0);
`endif

        // Word write then read, 2 wait states
        do_xact("sw", 0, 1'b1, 4'b1111, 32'h8000_0010, 32'hDEAD_BEEF, rd);
        do_xact("lw", 0, 1'b0, 4'b1111, 32'h8000_0010, 32'h0, rd);
        check("lw_const", rd, 32'hDEAD_BEEF);

        // Byte and half writes at lane offsets
        do_xact("bh_pre", 0, 1'b1, 4'b1111, 32'h8000_0020, 32'h0, rd);
        do_xact("sb", 0, 1'b1, 4'b0001, 32'h8000_0023, 32'h0000_00AB, rd);
        do_xact("sh", 0, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_1234, rd);
        do_xact("bh_lw", 0, 1'b0, 4'b1111, 32'h8000_0020, 32'h0, rd);
        check("bh_lw_const", rd, 32'hAB00_1234);
        do_xact("bh_lb", 0, 1'b0, 4'b0001, 32'h8000_0023, 32'h0, rd);
        check("bh_lb_const", rd, 32'h0000_00AB);

        // Misaligned, zero strobe and out of range leave the array untouched
        do_xact("err_pre", 0, 1'b1, 4'b1111, 32'h8000_0000, 32'h5A5A_A5A5, rd);
        do_xact("err_w_mis", 0, 1'b1, 4'b1111, 32'h8000_0002, 32'h1111_1111, rd);
        do_xact("err_h_mis", 0, 1'b1, 4'b0011, 32'h8000_0003, 32'h2222_2222, rd);
        do_xact("err_oor_w", 0, 1'b1, 4'b1111, 32'h8000_1000, 32'h3333_3333, rd);
        do_xact("err_oor_r", 0, 1'b0, 4'b1111, 32'h8000_1000, 32'h0, rd);
        do_xact("err_below", 0, 1'b0, 4'b1111, 32'h7FFF_FFFC, 32'h0, rd);
        do_xact("err_below_w", 0, 1'b1, 4'b1111, 32'h7FFF_FFFC, 32'h4444_4444, rd);
        do_xact("err_zero_st", 0, 1'b0, 4'b0000, 32'h8000_0000, 32'h0, rd);
        do_xact("err_keep", 0, 1'b0, 4'b1111, 32'h8000_0000, 32'h0, rd);
        check("err_keep_const", rd, 32'h5A5A_A5A5);

        // Back-to-back reads, 0 wait states
        for (int i = 0; i < 4; i++)
            do_xact($sformatf("b2b_pre%0d", i), 1, 1'b1, 4'b1111, 32'h8000_0040 + 32'(4*i), $urandom, rd);
        for (int i = 0; i < 4; i++)
            model(1, 1'b0, 4'b1111, 32'h8000_0040 + 32'(4*i), 32'h0, b2b_exp[i], dummy_er);
        @(negedge clk);
        check("b2b_ready_first", 32'(bus1.req_ready), 32'd1);
        drive(1, 1'b1, 1'b0, 4'b1111, 32'h8000_0040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ready%0d", i), 32'(bus1.req_ready), 32'd1);
            check($sformatf("b2b_rsp%0d", i), 32'(bus1.rsp_valid), 32'd1);
            check($sformatf("b2b_rdata%0d", i), bus1.rdata, b2b_exp[i]);
            if (i < 3) drive(1, 1'b1, 1'b0, 4'b1111, 32'h8000_0044 + 32'(4*i), 32'h0);
            else       drive(1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        end
        @(negedge clk);
        check("b2b_rsp_end", 32'(bus1.rsp_valid), 32'd0);

        // Randomized traffic on the 2- and 0-wait-state responders
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                do_xact($sformatf("rnd_pre%0d_%0d", d, w), d, 1'b1, 4'b1111, BASE + 32'h100 + 32'(4*w), $urandom, rd);
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 7))
                    0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
                    1:       a = BASE - 32'd4 - 32'($urandom_range(0, 63));
                    default: a = BASE + 32'h100 + 32'($urandom_range(0, 63));
                endcase
                st = st_tab[$urandom_range(0, 3)];
                do_xact($sformatf("rnd%0d_%0d", d, n), d, 1'($urandom_range(0, 1)), st, a, $urandom, rd);
            end
        end

        // Reset during WAIT discards the pending write
        do_xact("rmo_pre", 2, 1'b1, 4'b1111, 32'h8000_0030, 32'h2222_2222, rd);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 4'b1111, 32'h8000_0030, 32'h1111_1111);
        guard = 0;
        while (!bus2.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        check("rmo_ready_in_rst", 32'(bus2.req_ready), 32'd0);
        seen = 0;
        @(negedge clk);
        if (bus2.rsp_valid) seen++;
        check("rmo_ready_in_rst2", 32'(bus2.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid) seen++;
            if (i == 0) check("rmo_ready_after", 32'(bus2.req_ready), 32'd1);
        end
        check("rmo_no_rsp", 32'(seen), 32'd0);
        do_xact("rmo_read", 2, 1'b0, 4'b1111, 32'h8000_0030, 32'h0, rd);
        check("rmo_read_const", rd, 32'h2222_2222);

`ifdef DMEM_RESP_STATS_EN
        // Statistics: counters were cleared by the reset above; rmo_read counted as one read
        check("st_rd_after_rst_read", 32'(rd_c2), 32'd1);
        check("st_wr_after_rst", 32'(wr_c2), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("st_rd_zero", 32'(rd_c2), 32'd0);
        for (int i = 0; i < 3; i++)
            do_xact($sformatf("st_rd%0d", i), 2, 1'b0, 4'b1111, 32'h8000_0030, 32'h0, rd);
        for (int i = 0; i < 2; i++)
            do_xact($sformatf("st_wr%0d", i), 2, 1'b1, 4'b1111, 32'h8000_0034 + 32'(4*i), $urandom, rd);
        do_xact("st_err", 2, 1'b0, 4'b1111, 32'h8000_0031, 32'h0, rd);
        check("st_rd_cnt", 32'(rd_c2), 32'd3);
        check("st_wr_cnt", 32'(wr_c2), 32'd2);
        check("st_err_cnt", 32'(er_c2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("st_rd_clr", 32'(rd_c2), 32'd0);
        check("st_wr_clr", 32'(wr_c2), 32'd0);
        check("st_err_clr", 32'(er_c2), 32'd0);
        reset = 1'b0;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
